// File: rtl/nco_seq_ctrl.sv
// nco_seq_ctrl: phase-accumulator sequencer driving the carrier-offset NCO sin/cos ROM pair for a programmed burst.
// Latency: first rom_en one clock after start is sampled in ARMED; out_vld trails rom_en by exactly ROM_LAT clocks.
// Backpressure: none downstream (mixer must take every out_vld); config taken via cfg_valid/cfg_ready only in IDLE. Optional NCO_SEQ_DITHER_EN adds LFSR phase dither on rom_addr.
module nco_seq_ctrl #(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 10,
    parameter int ROM_LAT = 1,
    parameter int LEN_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_fcw,
    input  logic [PHASE_W-1:0] cfg_phase0,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               start,
    input  logic               abort,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               out_vld,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] DRAIN_LAST = 3'(ROM_LAT - 1);

    state_t               state;
    logic [PHASE_W-1:0]   acc;
    logic [PHASE_W-1:0]   fcw_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     cnt;
    logic [2:0]           drain_cnt;
    logic [ROM_LAT-1:0]   vld_sr;
    logic                 cfg_accept;
    logic                 issue;
    logic [ADDR_W-1:0]    addr_nxt;

    // A read is issued on the start cycle out of ARMED and on every RUN cycle until
    // len addresses are out or abort arrives; abort always wins over start.
    assign cfg_accept = (state == S_IDLE) && cfg_valid;
    assign issue      = !abort && (((state == S_ARMED) && start) ||
                                   ((state == S_RUN) && (cnt != len_q)));

`ifdef NCO_SEQ_DITHER_EN
    localparam int TRUNC_W = PHASE_W - ADDR_W;

    logic [15:0]        lfsr;
    logic               lfsr_fb;
    logic [PHASE_W-1:0] acc_dith;

    // Dither only perturbs the address, never the accumulator, so the carrier
    // frequency stays exact while truncation spurs get spread.
    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign acc_dith = acc + PHASE_W'(lfsr[TRUNC_W-1:0]);
    assign addr_nxt = acc_dith[PHASE_W-1 -: ADDR_W];

    // LFSR restarts from the same seed for every burst so bursts are repeatable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 16'hACE1;
        end else if (cfg_accept) begin
            lfsr <= 16'hACE1;
        end else if (issue) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end
`else
    assign addr_nxt = acc[PHASE_W-1 -: ADDR_W];
`endif

    // Main sequencer: config latch, burst address issue and drain timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            acc       <= '0;
            fcw_q     <= '0;
            len_q     <= '0;
            cnt       <= '0;
            drain_cnt <= '0;
        end else begin
            done   <= 1'b0;
            rom_en <= issue;
            if (issue) begin
                rom_addr <= addr_nxt;
                acc      <= acc + fcw_q;
                cnt      <= cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (cfg_accept) begin
                        fcw_q     <= cfg_fcw;
                        len_q     <= cfg_len;
                        acc       <= cfg_phase0;
                        cnt       <= '0;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (start) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // cnt wraps to zero after 2^LEN_W issues, which makes len 0 a full-range burst.
                    if (!issue) begin
                        drain_cnt <= '0;
                        state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Reads already in the ROM pipe finish here; abort is ignored.
                    if (drain_cnt == DRAIN_LAST) begin
                        state     <= S_IDLE;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Valid strobe follows the ROM read pipe so it lines up with ROM data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= rom_en;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    assign out_vld = vld_sr[ROM_LAT-1];

endmodule

// File: tb/tb_nco_seq_ctrl.sv
// tb_nco_seq_ctrl: directed scoreboard bench for nco_seq_ctrl (one instance with ROM_LAT=2, one with LEN_W=4).
// Expected ROM addresses are queued when a burst is configured and popped as rom_en / out_vld appear.
// Outputs are sampled on the falling clock edge; inputs change right after that sample.
module tb_nco_seq_ctrl;

    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_cfg_valid, a_cfg_ready, a_start, a_abort;
    logic        a_rom_en, a_out_vld, a_busy, a_done;
    logic [15:0] a_fcw, a_ph0;
    logic [11:0] a_len;
    logic [9:0]  a_rom_addr;

    logic        b_cfg_valid, b_cfg_ready, b_start, b_abort;
    logic        b_rom_en, b_out_vld, b_busy, b_done;
    logic [15:0] b_fcw, b_ph0;
    logic [3:0]  b_len;
    logic [9:0]  b_rom_addr;

    nco_seq_ctrl #(.ROM_LAT(LAT)) u_a (
        .clk(clk), .rst(rst), .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready),
        .cfg_fcw(a_fcw), .cfg_phase0(a_ph0), .cfg_len(a_len), .start(a_start),
        .abort(a_abort), .rom_en(a_rom_en), .rom_addr(a_rom_addr),
        .out_vld(a_out_vld), .busy(a_busy), .done(a_done)
    );

    nco_seq_ctrl #(.LEN_W(4), .ROM_LAT(1)) u_b (
        .clk(clk), .rst(rst), .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
        .cfg_fcw(b_fcw), .cfg_phase0(b_ph0), .cfg_len(b_len), .start(b_start),
        .abort(b_abort), .rom_en(b_rom_en), .rom_addr(b_rom_addr),
        .out_vld(b_out_vld), .busy(b_busy), .done(b_done)
    );

    // Behavioural ROM for instance A: read registered on rom_en, then LAT-1 more stages.
    logic [9:0] rom_pipe [LAT];
    always @(posedge clk) begin
        if (a_rom_en) rom_pipe[0] <= a_rom_addr;
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [9:0] a_addr_q[$];
    logic [9:0] a_data_q[$];
    logic [9:0] b_addr_q[$];
    int a_en_cnt = 0, a_vld_cnt = 0, a_done_cnt = 0;
    int b_en_cnt = 0, b_vld_cnt = 0, b_done_cnt = 0;
    int a_en_start = 0, a_vld_start = 0, a_last_vld = 0, a_done_cyc = 0;
    bit a_prev_en = 1'b0, a_prev_vld = 1'b0;
    int e0, v0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge and run the scoreboard on both instances.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (rst) begin
            if (a_rom_en) begin
                a_en_cnt++;
                if (!a_prev_en) a_en_start = cyc;
                if (a_addr_q.size() == 0) check("a_rom_en_unexpected", 32'(a_rom_en), 0);
                else check("a_rom_addr", 32'(a_rom_addr), 32'(a_addr_q.pop_front()));
            end
            if (a_out_vld) begin
                a_vld_cnt++;
                a_last_vld = cyc;
                if (!a_prev_vld) a_vld_start = cyc;
                if (a_data_q.size() == 0) check("a_out_vld_unexpected", 32'(a_out_vld), 0);
                else check("a_rom_data", 32'(rom_pipe[LAT-1]), 32'(a_data_q.pop_front()));
            end
            if (a_done) begin
                a_done_cnt++;
                a_done_cyc = cyc;
            end
            if (b_rom_en) begin
                b_en_cnt++;
                if (b_addr_q.size() == 0) check("b_rom_en_unexpected", 32'(b_rom_en), 0);
                else check("b_rom_addr", 32'(b_rom_addr), 32'(b_addr_q.pop_front()));
            end
            if (b_out_vld) b_vld_cnt++;
            if (b_done) b_done_cnt++;
        end
        a_prev_en  = a_rom_en;
        a_prev_vld = a_out_vld;
    endtask

    task automatic run_a_until_done(input int max);
        int d0 = a_done_cnt;
        int n = 0;
        while (a_done_cnt == d0 && n < max) begin
            step();
            n++;
        end
        check("a_done_seen", 32'(a_done_cnt - d0), 1);
    endtask

    task automatic cfg_a(input logic [15:0] fcw, input logic [15:0] ph0, input logic [11:0] len);
        a_cfg_valid = 1'b1; a_fcw = fcw; a_ph0 = ph0; a_len = len;
        step();
        a_cfg_valid = 1'b0;
        check("a_armed_cfg_ready", 32'(a_cfg_ready), 0);
        check("a_armed_busy", 32'(a_busy), 1);
    endtask

    task automatic burst_a_tail(input string tag, input int n);
        check({tag, "_en_cnt"}, 32'(a_en_cnt - e0), 32'(n));
        check({tag, "_vld_cnt"}, 32'(a_vld_cnt - v0), 32'(n));
        check({tag, "_vld_lat"}, 32'(a_vld_start - a_en_start), LAT);
        check({tag, "_done_after_vld"}, 32'(a_done_cyc - a_last_vld), 1);
        check({tag, "_queue_left"}, 32'(a_addr_q.size() + a_data_q.size()), 0);
        check({tag, "_cfg_ready"}, 32'(a_cfg_ready), 1);
        check({tag, "_busy"}, 32'(a_busy), 0);
    endtask

    task automatic push_a(input logic [9:0] addr);
        a_addr_q.push_back(addr);
        a_data_q.push_back(addr);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        a_cfg_valid = 0; a_start = 0; a_abort = 0; a_fcw = 0; a_ph0 = 0; a_len = 0;
        b_cfg_valid = 0; b_start = 0; b_abort = 0; b_fcw = 0; b_ph0 = 0; b_len = 0;
        step(); step();
        check("rst_cfg_ready", 32'(a_cfg_ready), 1);
        check("rst_rom_en", 32'(a_rom_en), 0);
        check("rst_rom_addr", 32'(a_rom_addr), 0);
        check("rst_out_vld", 32'(a_out_vld), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_done", 32'(a_done), 0);
        check("rst_b_cfg_ready", 32'(b_cfg_ready), 1);
        check("rst_b_busy", 32'(b_busy), 0);
        rst = 1'b1;
        step();

        // Basic ramp: fcw 0x40 steps the top 10 bits by one.
        cfg_a(16'h0040, 16'h0000, 12'd8);
        for (int k = 0; k < 8; k++) push_a(10'(k));
        e0 = a_en_cnt; v0 = a_vld_cnt;
        a_start = 1'b1; step(); a_start = 1'b0;
        run_a_until_done(60);
        burst_a_tail("ramp", 8);
        step();
        check("ramp_done_pulse_one", 32'(a_done), 0);

        // Wrap: 0xC000 + n*0x4000.
        cfg_a(16'h4000, 16'hC000, 12'd4);
        push_a(10'd768); push_a(10'd0); push_a(10'd256); push_a(10'd512);
        e0 = a_en_cnt; v0 = a_vld_cnt;
        a_start = 1'b1; step(); a_start = 1'b0;
        run_a_until_done(40);
        burst_a_tail("wrap", 4);

        // len 0 on the LEN_W=4 instance means 16 samples.
        b_cfg_valid = 1'b1; b_fcw = 16'h0400; b_ph0 = 16'h0000; b_len = 4'd0;
        step();
        b_cfg_valid = 1'b0;
        check("b_armed_cfg_ready", 32'(b_cfg_ready), 0);
        for (int k = 0; k < 16; k++) b_addr_q.push_back(10'(16 * k));
        e0 = b_en_cnt; v0 = b_vld_cnt;
        begin
            int d0 = b_done_cnt;
            int n = 0;
            b_start = 1'b1; step(); b_start = 1'b0;
            while (b_done_cnt == d0 && n < 100) begin step(); n++; end
            check("len0_done_seen", 32'(b_done_cnt - d0), 1);
        end
        check("len0_en_cnt", 32'(b_en_cnt - e0), 16);
        check("len0_vld_cnt", 32'(b_vld_cnt - v0), 16);
        check("len0_queue_left", 32'(b_addr_q.size()), 0);

        // Abort on the 3rd RUN cycle, held into DRAIN where it must be ignored.
        cfg_a(16'h0040, 16'h1000, 12'd100);
        push_a(10'd64); push_a(10'd65); push_a(10'd66);
        e0 = a_en_cnt; v0 = a_vld_cnt;
        a_start = 1'b1; step(); a_start = 1'b0;
        step(); step();
        a_abort = 1'b1; step(); step(); a_abort = 1'b0;
        run_a_until_done(20);
        burst_a_tail("abort", 3);

        // cfg_valid held high with a different fcw while busy: no re-accept.
        cfg_a(16'h0040, 16'h0000, 12'd6);
        for (int k = 0; k < 6; k++) push_a(10'(k));
        a_cfg_valid = 1'b1; a_fcw = 16'h0100;
        e0 = a_en_cnt; v0 = a_vld_cnt;
        a_start = 1'b1; step(); a_start = 1'b0;
        step();
        check("hold_run_cfg_ready", 32'(a_cfg_ready), 0);
        run_a_until_done(40);
        a_cfg_valid = 1'b0;
        burst_a_tail("hold", 6);

        // start and abort together in ARMED: abort wins.
        cfg_a(16'h0040, 16'h0000, 12'd5);
        e0 = a_en_cnt;
        a_start = 1'b1; a_abort = 1'b1; step(); a_start = 1'b0; a_abort = 1'b0;
        check("sa_done", 32'(a_done), 1);
        check("sa_cfg_ready", 32'(a_cfg_ready), 1);
        check("sa_busy", 32'(a_busy), 0);
        step(); step();
        check("sa_no_rom_en", 32'(a_en_cnt - e0), 0);

        // FCW 0: DC carrier, constant address 0x5555 >> 6.
        cfg_a(16'h0000, 16'h5555, 12'd3);
        for (int k = 0; k < 3; k++) push_a(10'd341);
        e0 = a_en_cnt; v0 = a_vld_cnt;
        a_start = 1'b1; step(); a_start = 1'b0;
        run_a_until_done(30);
        burst_a_tail("dc", 3);

        // Asynchronous reset in the middle of a burst.
        cfg_a(16'h0040, 16'h0000, 12'd50);
        for (int k = 0; k < 50; k++) push_a(10'(k));
        a_start = 1'b1; step(); a_start = 1'b0;
        step(); step();
        check("mid_busy_before_rst", 32'(a_busy), 1);
        check("mid_vld_before_rst", 32'(a_out_vld), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_rom_en", 32'(a_rom_en), 0);
        check("arst_out_vld", 32'(a_out_vld), 0);
        check("arst_busy", 32'(a_busy), 0);
        check("arst_rom_addr", 32'(a_rom_addr), 0);
        check("arst_cfg_ready", 32'(a_cfg_ready), 1);
        a_addr_q.delete();
        a_data_q.delete();
        step(); step();
        rst = 1'b1;
        step();
        check("post_rst_cfg_ready", 32'(a_cfg_ready), 1);
        check("post_rst_busy", 32'(a_busy), 0);
        check("post_rst_out_vld", 32'(a_out_vld), 0);

        // Recovery burst after reset.
        cfg_a(16'h0040, 16'h0080, 12'd2);
        push_a(10'd2); push_a(10'd3);
        e0 = a_en_cnt; v0 = a_vld_cnt;
        a_start = 1'b1; step(); a_start = 1'b0;
        run_a_until_done(30);
        burst_a_tail("recover", 2);

        step(); step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
